reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Architectural register file of the 20-bit pipeline, directly downstream of the writeback-select stage.
- Consumes RW, Dest and WBData on the write port.
- Serves two combinational read ports to decode, plus one debug read port.
- Keeps a saturating count of retired register writebacks.

Parameters:
DATA_W, 20, register/data width in bits
ADDR_W, 4, register address width; register count = 2**ADDR_W (16)
CNT_W, 16, width of retired-writeback counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
RW  input  1  writeback enable from writeback-select stage
Dest  input  ADDR_W  destination register index
WBData  input  DATA_W  writeback data
ra1  input  ADDR_W  read port 1 address
ra2  input  ADDR_W  read port 2 address
rd1  output  DATA_W  read port 1 data (combinational)
rd2  output  DATA_W  read port 2 data (combinational)
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  DATA_W  debug read data (registered, 1-cycle latency)
wb_count  output  CNT_W  retired writebacks to R1..R15, saturating

Behaviour:
- Reset: while rst=1, asynchronously clear regs[0..15], dbg_data and wb_count to 0. rd1/rd2 then read 0.
- Reset mid-operation: a write presented on an edge where rst=1 is discarded. Normal operation resumes on the first rising edge with rst=0.
- R0 is hardwired zero:
  - Reads of address 0 on any port return 0.
  - RW=1 with Dest=0 changes no state and does not increment wb_count.
- Write: on rising edge with RW=1 and Dest!=0, regs[Dest] <= WBData and wb_count increments.
- wb_count saturates at 2**CNT_W-1 (0xFFFF); further writes leave it unchanged.
- Reads (rd1, rd2):
  - Purely combinational from regs, zero-cycle latency.
  - Both ports are independent and may address the same register.
- Read-during-write, same address, same cycle: behaviour set by REGFILE_BYPASS_EN (below).
- Debug port: dbg_data <= (dbg_addr==0) ? 0 : regs[dbg_addr] each rising edge.
  - Reflects state before that edge's write. No bypass on this port in either build.
- RW=0: no state change; Dest and WBData are don't-care.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - If RW=1, Dest!=0 and ra1==Dest, rd1 = WBData in the same cycle; likewise for rd2/ra2.
  - Bypass is suppressed while rst=1.
  - Resolves the WB->ID hazard with no extra pipeline stall.
- Not defined: rd1/rd2 return the pre-write register contents. The new value is visible from the cycle after the edge; the hazard unit must stall one cycle.

Decomposition:
- Shared package holds:
  - DATA_W=20, ADDR_W=4.
  - Register index constant REG_ZERO=0.
  - Typedef for data word and register index, also used by the writeback-select stage and decode.
- One natural sub-module: reg_file_bypass, a per-port compare/mux of (RW, Dest, WBData, ra) -> rd.
  - Instantiated twice when REGFILE_BYPASS_EN is defined.
  - Otherwise a straight register read with the R0 zero-force.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing R3=0x12345 -> rd1(ra1=3)=0 and wb_count=0 immediately, without waiting for a clock edge. After release, R3 reads 0.
- Basic write/read: RW=1, Dest=5, WBData=0xABCDE, one edge, then ra1=5, ra2=5 -> rd1=rd2=0xABCDE, wb_count=1.
- R0 protection: RW=1, Dest=0, WBData=0xFFFFF -> rd1(ra1=0)=0, wb_count unchanged, dbg_data(dbg_addr=0)=0.
- Same-cycle read/write: R7=0x00011, then RW=1, Dest=7, WBData=0x00022, ra1=7 before the edge:
  - With REGFILE_BYPASS_EN: rd1=0x00022.
  - Without REGFILE_BYPASS_EN: rd1=0x00011.
  - Both builds: rd1=0x00022 after the edge.
- Saturation: force 65537 writes to R1 (or CNT_W=4 with 17 writes) -> wb_count sticks at all-ones (0xFFFF or 0xF).
- Write during reset: rst=1 with RW=1, Dest=9, WBData=0x55555 across an edge, release rst -> R9=0, wb_count=0.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared types and sizes for the 20-bit pipeline register file.
// Used by writeback-select, decode and reg_file_wb.
package reg_file_wb_pkg;

    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 4;
    localparam int NREG     = 1 << ADDR_W;
    localparam int WB_CNT_W = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] ridx_t;

    localparam ridx_t REG_ZERO = '0;

    function automatic logic is_wr(input logic rw, input ridx_t dest);
        return rw && (dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Write/read/debug bundle between the pipeline and reg_file_wb.
// master = pipeline side, slave = register file.
interface reg_file_wb_if
    import reg_file_wb_pkg::*;
#(
    parameter int CNT_W = WB_CNT_W
);

    logic             RW;
    ridx_t            Dest;
    word_t            WBData;
    ridx_t            ra1;
    ridx_t            ra2;
    word_t            rd1;
    word_t            rd2;
    ridx_t            dbg_addr;
    word_t            dbg_data;
    logic [CNT_W-1:0] wb_count;

    modport master (
        output RW, Dest, WBData, ra1, ra2, dbg_addr,
        input  rd1, rd2, dbg_data, wb_count
    );

    modport slave (
        input  RW, Dest, WBData, ra1, ra2, dbg_addr,
        output rd1, rd2, dbg_data, wb_count
    );

endinterface

// File: rtl/reg_file_wb_bypass.sv
// One read port: R0 zero-force plus optional write-through of the
// in-flight writeback when byp_en_i is high and addresses match.
module reg_file_wb_bypass
    import reg_file_wb_pkg::*;
(
    input  logic  byp_en_i,
    input  ridx_t dest_i,
    input  word_t wdata_i,
    input  ridx_t ra_i,
    input  word_t rdata_i,
    output word_t rd_o
);

    always_comb begin
        rd_o = rdata_i;
        if (ra_i == REG_ZERO) begin
            rd_o = '0;
        end else if (byp_en_i && (ra_i == dest_i)) begin
            rd_o = wdata_i;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file: 2 comb read ports, registered debug read,
// saturating writeback counter. REGFILE_BYPASS_EN enables WB->ID write-through.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int CNT_W = WB_CNT_W
)(
    input  logic          clk,
    input  logic          rst,
    reg_file_wb_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    word_t            regs_q [NREG];
    word_t            dbg_q, dbg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we;
    logic             byp_en;

    assign we = is_wr(bus.RW, bus.Dest);

`ifdef REGFILE_BYPASS_EN
    assign byp_en = we && !rst;
`else
    assign byp_en = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (we && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // debug port sees pre-write state, never bypassed
    always_comb begin
        dbg_d = regs_q[bus.dbg_addr];
        if (bus.dbg_addr == REG_ZERO) begin
            dbg_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[bus.Dest] <= bus.WBData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            dbg_q <= dbg_d;
            cnt_q <= cnt_d;
        end
    end

    reg_file_wb_bypass u_byp1 (
        .byp_en_i (byp_en),
        .dest_i   (bus.Dest),
        .wdata_i  (bus.WBData),
        .ra_i     (bus.ra1),
        .rdata_i  (regs_q[bus.ra1]),
        .rd_o     (bus.rd1)
    );

    reg_file_wb_bypass u_byp2 (
        .byp_en_i (byp_en),
        .dest_i   (bus.Dest),
        .wdata_i  (bus.WBData),
        .ra_i     (bus.ra2),
        .rdata_i  (regs_q[bus.ra2]),
        .rd_o     (bus.rd2)
    );

    assign bus.dbg_data = dbg_q;
    assign bus.wb_count = cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed plan plus random traffic
// against an array model of the register file.
module tb_reg_file_wb;
    import reg_file_wb_pkg::*;

    localparam int unsigned CNT_MAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    reg_file_wb_if bus ();

    reg_file_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int fails = 0;

    logic [19:0] m [16];
    int unsigned mcnt;
    logic [19:0] mdbg;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_rd(input logic [3:0] a);
        if (a == 4'd0) return 20'd0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && bus.RW && bus.Dest == a) return bus.WBData;
`endif
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 20'd0;
        mcnt = 0;
        mdbg = 20'd0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            mdbg = (bus.dbg_addr == 4'd0) ? 20'd0 : m[bus.dbg_addr];
            if (bus.RW && bus.Dest != 4'd0) begin
                m[bus.Dest] = bus.WBData;
                if (mcnt < CNT_MAX) mcnt++;
            end
        end
    endtask

    task automatic drive(input logic rw, input logic [3:0] dest,
                         input logic [19:0] data, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] da);
        bus.RW       = rw;
        bus.Dest     = dest;
        bus.WBData   = data;
        bus.ra1      = a1;
        bus.ra2      = a2;
        bus.dbg_addr = da;
    endtask

    task automatic step(input string tag, input logic rw,
                        input logic [3:0] dest, input logic [19:0] data,
                        input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] da);
        @(negedge clk);
        drive(rw, dest, data, a1, a2, da);
        #1;
        check({tag, ".rd1"}, 32'(bus.rd1), 32'(exp_rd(a1)));
        check({tag, ".rd2"}, 32'(bus.rd2), 32'(exp_rd(a2)));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".dbg"}, 32'(bus.dbg_data), 32'(mdbg));
        check({tag, ".cnt"}, 32'(bus.wb_count), mcnt);
    endtask

    initial begin
        logic [3:0] d, a1, a2;
        drive(1'b0, 4'd0, 20'd0, 4'd3, 4'd7, 4'd0);
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("rst.rd1", 32'(bus.rd1), 32'd0);
        check("rst.cnt", 32'(bus.wb_count), 32'd0);
        check("rst.dbg", 32'(bus.dbg_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        step("wr5", 1'b1, 4'd5, 20'hABCDE, 4'd5, 4'd5, 4'd0);
        step("rd5", 1'b0, 4'd0, 20'd0, 4'd5, 4'd5, 4'd5);
        check("basic.rd1", 32'(bus.rd1), 32'h0ABCDE);
        check("basic.rd2", 32'(bus.rd2), 32'h0ABCDE);
        check("basic.cnt", 32'(bus.wb_count), 32'd1);
        check("basic.dbg", 32'(bus.dbg_data), 32'h0ABCDE);

        step("r0", 1'b1, 4'd0, 20'hFFFFF, 4'd0, 4'd0, 4'd0);
        check("r0.rd1", 32'(bus.rd1), 32'd0);
        check("r0.cnt", 32'(bus.wb_count), 32'd1);
        check("r0.dbg", 32'(bus.dbg_data), 32'd0);

        step("r7a", 1'b1, 4'd7, 20'h00011, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        drive(1'b1, 4'd7, 20'h00022, 4'd7, 4'd0, 4'd7);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw.pre", 32'(bus.rd1), 32'h00022);
`else
        check("raw.pre", 32'(bus.rd1), 32'h00011);
`endif
        @(posedge clk);
        model_edge();
        #1;
        check("raw.post", 32'(bus.rd1), 32'h00022);
        check("raw.dbg", 32'(bus.dbg_data), 32'h00011);

        for (int i = 0; i < 400; i++) begin
            d  = 4'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? d : 4'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? d : 4'($urandom);
            step("rnd", 1'($urandom), d, 20'($urandom), a1, a2,
                 4'($urandom));
        end

        step("r3", 1'b1, 4'd3, 20'h12345, 4'd3, 4'd0, 4'd3);
        @(negedge clk);
        drive(1'b0, 4'd0, 20'd0, 4'd3, 4'd3, 4'd3);
        #2 rst = 1'b1;
        #1;
        check("async.rd1", 32'(bus.rd1), 32'd0);
        check("async.cnt", 32'(bus.wb_count), 32'd0);
        check("async.dbg", 32'(bus.dbg_data), 32'd0);
        model_reset();

        drive(1'b1, 4'd9, 20'h55555, 4'd9, 4'd3, 4'd9);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 20'd0, 4'd9, 4'd3, 4'd9);
        #1;
        check("wrst.r9", 32'(bus.rd1), 32'd0);
        check("wrst.r3", 32'(bus.rd2), 32'd0);
        check("wrst.cnt", 32'(bus.wb_count), 32'd0);
        step("wrst.post", 1'b0, 4'd0, 20'd0, 4'd9, 4'd3, 4'd9);

        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            drive(1'b1, 4'd1, 20'($urandom), 4'd2, 4'd0, 4'd0);
            @(posedge clk);
            model_edge();
            if (i == 65533) begin
                #1;
                check("sat.near", 32'(bus.wb_count), 32'd65534);
            end
        end
        #1;
        check("sat.cnt", 32'(bus.wb_count), 32'h0000FFFF);
        step("sat.hold", 1'b1, 4'd1, 20'h0F0F0, 4'd1, 4'd1, 4'd1);
        step("sat.rd", 1'b0, 4'd0, 20'd0, 4'd1, 4'd0, 4'd1);
        check("sat.final", 32'(bus.wb_count), 32'h0000FFFF);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
